branch_flag_gen: RTL and testbench
==================================

BRANCH_FLAG_GEN -- requirements
Module: branch_flag_gen

Interface
REQ-001 Parameter: XLEN, default 32, operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rs1  input  XLEN  first branch operand.
REQ-005 rs2  input  XLEN  second branch operand.
REQ-006 funct3_in  input  3  branch condition code, passed through unchanged.
REQ-007 branch_in  input  1  instruction is a conditional branch.
REQ-008 valid_in  input  1  stage input holds a real instruction.
REQ-009 stall  input  1  hold the output register.
REQ-010 flush  input  1  kill the instruction entering the output register.
REQ-011 cf, zf, vf, sf  output  1 each  registered carry, zero, overflow, sign flags for the branch resolver.
REQ-012 funct3_out  output  3  registered funct3_in.
REQ-013 branch_out  output  1  registered branch_in, qualified by valid.
REQ-014 valid_out  output  1  registered instruction-valid.
REQ-015 branch_cnt  output  16  saturating count of valid branches accepted.

Function
REQ-016 Compute diff = rs1 + ~rs2 + 1 at XLEN+1 bits; carry = bit XLEN.
REQ-017 Flag definitions:
- zf = (diff[XLEN-1:0] == 0)
- sf = diff[XLEN-1]
- cf = carry; 1 means no borrow, i.e. rs1 >= rs2 unsigned
- vf = (rs1[MSB] != rs2[MSB]) & (diff[MSB] != rs1[MSB])
REQ-018 Latency is exactly one cycle: operands sampled on edge N appear on the outputs after edge N.
REQ-019 Normal update (no rst, flush, or stall): all output registers load the new values; branch_out = branch_in & valid_in.
REQ-020 stall=1 with flush=0: every output register, including branch_cnt, holds its value.
REQ-021 flush=1: valid_out <= 0 and branch_out <= 0; flags and funct3_out <= 0; branch_cnt does not increment. Flush wins over stall.
REQ-022 valid_in=0 without flush: valid_out <= 0 and branch_out <= 0; flags still update from the operands (don't-care to consumers).
REQ-023 branch_cnt increments by 1 on each edge where valid_in & branch_in & ~stall & ~flush & ~rst.
- Saturates at 16'hFFFF.
- Never wraps.
REQ-024 Consumers treat flags as meaningful only when valid_out & branch_out.
REQ-025 Flags depend only on rs1 and rs2, never on funct3_in.

Reset
REQ-026 rst=1 at an edge forces to 0: cf, zf, vf, sf, funct3_out, branch_out, valid_out, branch_cnt.
REQ-027 rst has priority over flush and stall, including mid-stall.
REQ-028 The first edge after rst deasserts performs a normal update.

Verification
REQ-029 Equal operands: rs1=rs2=32'h0000_0005, branch_in=1, valid_in=1 -> next cycle zf=1, cf=1, sf=0, vf=0, branch_out=1, branch_cnt=1.
REQ-030 Signed/unsigned split: rs1=32'hFFFF_FFFF, rs2=32'h0000_0001 -> zf=0, sf=1, vf=0, cf=1 (signed less-than, unsigned greater-or-equal).
REQ-031 Overflow: rs1=32'h8000_0000, rs2=32'h0000_0001 -> diff=32'h7FFF_FFFF, sf=0, vf=1, cf=1.
REQ-032 Stall then flush: load funct3_in=3'b101, then assert stall 3 cycles with new operands -> outputs unchanged and branch_cnt unchanged; then assert flush with stall -> valid_out=0, branch_out=0.
REQ-033 Saturation: preload 16'hFFFE, issue 3 valid branches -> branch_cnt reads 16'hFFFF, 16'hFFFF, 16'hFFFF.
REQ-034 Reset mid-stream: rst=1 while stall=1 and valid_out=1 -> all outputs 0 next cycle; the first post-reset branch gives branch_cnt=1.

Source files
------------

// File: rtl/branch_flag_if.sv
// branch_flag_if: operand, control and flag bundle between issue logic and branch_flag_gen
interface branch_flag_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0] funct3_in;
  logic branch_in;
  logic valid_in;
  logic stall;
  logic flush;
  logic cf;
  logic zf;
  logic vf;
  logic sf;
  logic [2:0] funct3_out;
  logic branch_out;
  logic valid_out;
  logic [15:0] branch_cnt;
  modport master (
    output rs1, rs2, funct3_in, branch_in, valid_in, stall, flush,
    input cf, zf, vf, sf, funct3_out, branch_out, valid_out, branch_cnt
  );
  modport slave (
    input rs1, rs2, funct3_in, branch_in, valid_in, stall, flush,
    output cf, zf, vf, sf, funct3_out, branch_out, valid_out, branch_cnt
  );
endinterface

// File: rtl/branch_flag_gen.sv
// branch_flag_gen: registers subtract-derived carry/zero/overflow/sign flags for the branch resolver
module branch_flag_gen #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  branch_flag_if.slave bus
);
  logic [XLEN:0] diff;
  logic zf_n, sf_n, cf_n, vf_n, take;
  always_comb begin
    diff = {1'b0, bus.rs1} + {1'b0, ~bus.rs2} + {{XLEN{1'b0}}, 1'b1};
    zf_n = diff[XLEN-1:0] == '0;
    sf_n = diff[XLEN-1];
    cf_n = diff[XLEN];
    vf_n = (bus.rs1[XLEN-1] != bus.rs2[XLEN-1]) & (diff[XLEN-1] != bus.rs1[XLEN-1]);
    take = bus.valid_in & bus.branch_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {bus.cf, bus.zf, bus.vf, bus.sf} <= '0;
      bus.funct3_out <= '0;
      bus.branch_out <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.branch_cnt <= '0;
    end else if (bus.flush) begin
      {bus.cf, bus.zf, bus.vf, bus.sf} <= '0;
      bus.funct3_out <= '0;
      bus.branch_out <= 1'b0;
      bus.valid_out <= 1'b0;
    end else if (!bus.stall) begin
      {bus.cf, bus.zf, bus.vf, bus.sf} <= {cf_n, zf_n, vf_n, sf_n};
      bus.funct3_out <= bus.funct3_in;
      bus.branch_out <= take;
      bus.valid_out <= bus.valid_in;
      bus.branch_cnt <= (take && bus.branch_cnt != 16'hFFFF) ? bus.branch_cnt + 16'd1 : bus.branch_cnt;
    end
  end
endmodule

// File: tb/tb_branch_flag_gen.sv
// tb_branch_flag_gen: directed-vector bench for branch_flag_gen
module tb_branch_flag_gen;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  branch_flag_if #(.XLEN(32)) bus ();
  branch_flag_gen #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic br, input logic v, input logic st, input logic fl);
    bus.rs1 = a; bus.rs2 = b; bus.funct3_in = f3;
    bus.branch_in = br; bus.valid_in = v; bus.stall = st; bus.flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h1234, 32'h99, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); step();
    checks++;
    if ({bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out, bus.branch_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got cf%b zf%b vf%b sf%b f3=%b br%b v%b cnt=%h want all zero",
               bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out, bus.branch_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_equal();
    drive(32'h5, 32'h5, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.zf, bus.cf, bus.sf, bus.vf} !== 4'b1100) begin
      errors++;
      $display("FAIL equal_flags got zf,cf,sf,vf=%b want 1100", {bus.zf, bus.cf, bus.sf, bus.vf});
    end
    checks++;
    if ({bus.branch_out, bus.valid_out, bus.funct3_out} !== 5'b11000 || bus.branch_cnt !== 16'd1) begin
      errors++;
      $display("FAIL equal_ctrl got br%b v%b f3=%b cnt=%h want br1 v1 f3=000 cnt=0001",
               bus.branch_out, bus.valid_out, bus.funct3_out, bus.branch_cnt);
    end
  endtask

  task automatic test_signed_split();
    drive(32'hFFFF_FFFF, 32'h1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.zf, bus.sf, bus.vf, bus.cf} !== 4'b0101 || bus.branch_cnt !== 16'd2) begin
      errors++;
      $display("FAIL signed_split got zf,sf,vf,cf=%b cnt=%h want 0101 cnt=0002",
               {bus.zf, bus.sf, bus.vf, bus.cf}, bus.branch_cnt);
    end
    drive(32'h1, 32'hFFFF_FFFF, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.zf, bus.sf, bus.vf, bus.cf} !== 4'b0000 || bus.funct3_out !== 3'b110) begin
      errors++;
      $display("FAIL unsigned_less got zf,sf,vf,cf=%b f3=%b want 0000 f3=110",
               {bus.zf, bus.sf, bus.vf, bus.cf}, bus.funct3_out);
    end
  endtask

  task automatic test_overflow();
    drive(32'h8000_0000, 32'h1, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.zf, bus.sf, bus.vf, bus.cf} !== 4'b0011 || bus.branch_cnt !== 16'd4) begin
      errors++;
      $display("FAIL overflow got zf,sf,vf,cf=%b cnt=%h want 0011 cnt=0004",
               {bus.zf, bus.sf, bus.vf, bus.cf}, bus.branch_cnt);
    end
    drive(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.zf, bus.sf, bus.vf, bus.cf} !== 4'b0110) begin
      errors++;
      $display("FAIL overflow_pos got zf,sf,vf,cf=%b want 0110", {bus.zf, bus.sf, bus.vf, bus.cf});
    end
  endtask

  task automatic test_invalid();
    drive(32'h3, 32'h3, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.valid_out, bus.branch_out, bus.zf, bus.cf} !== 4'b0011 || bus.branch_cnt !== 16'd5) begin
      errors++;
      $display("FAIL invalid_in got v%b br%b zf%b cf%b cnt=%h want v0 br0 zf1 cf1 cnt=0005",
               bus.valid_out, bus.branch_out, bus.zf, bus.cf, bus.branch_cnt);
    end
    drive(32'h3, 32'h3, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.valid_out, bus.branch_out} !== 2'b10 || bus.branch_cnt !== 16'd5) begin
      errors++;
      $display("FAIL non_branch got v%b br%b cnt=%h want v1 br0 cnt=0005",
               bus.valid_out, bus.branch_out, bus.branch_cnt);
    end
  endtask

  task automatic test_stall_flush();
    drive(32'd10, 32'd3, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(32'd3 + i, 32'd10, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      checks++;
      if ({bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out} !== 9'b1000_101_11
          || bus.branch_cnt !== 16'd6) begin
        errors++;
        $display("FAIL stall_hold[%0d] got cf%b zf%b vf%b sf%b f3=%b br%b v%b cnt=%h want 1000 101 11 cnt=0006",
                 i, bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out, bus.branch_cnt);
      end
    end
    drive(32'd7, 32'd7, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    checks++;
    if ({bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out} !== 9'd0
        || bus.branch_cnt !== 16'd6) begin
      errors++;
      $display("FAIL flush_over_stall got cf%b zf%b vf%b sf%b f3=%b br%b v%b cnt=%h want all zero cnt=0006",
               bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out, bus.branch_cnt);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    drive(32'd1, 32'd2, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 65534; i++) step();
    checks++;
    if (bus.branch_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload got cnt=%h want fffe", bus.branch_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.branch_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_hold[%0d] got cnt=%h want ffff", i, bus.branch_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(32'd9, 32'd1, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'd9, 32'd1, 3'b101, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    checks++;
    if ({bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out, bus.branch_cnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid got cf%b zf%b vf%b sf%b f3=%b br%b v%b cnt=%h want all zero",
               bus.cf, bus.zf, bus.vf, bus.sf, bus.funct3_out, bus.branch_out, bus.valid_out, bus.branch_cnt);
    end
    rst = 1'b0;
    drive(32'd2, 32'd9, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.branch_cnt !== 16'd1 || {bus.valid_out, bus.branch_out, bus.cf, bus.sf} !== 4'b1101) begin
      errors++;
      $display("FAIL post_reset got cnt=%h v%b br%b cf%b sf%b want cnt=0001 v1 br1 cf0 sf1",
               bus.branch_cnt, bus.valid_out, bus.branch_out, bus.cf, bus.sf);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signed_split();
    test_overflow();
    test_invalid();
    test_stall_flush();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
